// File: rtl/fmc_i2c_cmd_sequencer.sv
// fmc_i2c_cmd_sequencer
// Walks a fixed I2C command program that switches on LED4 through the FMC424 CPLD
// (7-bit address 0x3E, register 0x02, data 0x01). It issues one command at a time
// to the byte/bit controller and waits for that command's response. A slave NACK
// makes it send a STOP and retry the whole transaction, up to RETRY_MAX more times.
// A missing response aborts with a timeout.
// Optional feature macro: FMC_I2C_READBACK_EN. When it is defined, the program reads
// the register back after the write and checks that the value is 0x01.
module fmc_i2c_cmd_sequencer #(
    parameter int RETRY_MAX      = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       go,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_data,
    output logic [7:0] rd_byte
);

    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NACK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
`ifdef FMC_I2C_READBACK_EN
    localparam logic [1:0] ERR_MISMATCH = 2'b11;
    localparam logic [3:0] LAST_STEP    = 4'd11;
`else
    localparam logic [3:0] LAST_STEP    = 4'd4;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_RECOVER,
        S_REC_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state_q;
    logic [3:0]      step_q;
    logic [3:0]      step_d;
    logic [RW-1:0]   retry_cnt_q;
    logic [TW-1:0]   timer_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic [1:0]      err_code_q;
    logic            cmd_valid_q;
    logic [1:0]      cmd_op_q;
    logic [7:0]      cmd_data_q;
    logic [7:0]      rd_byte_q;

    // Program ROM: {op, data} for each step. START/STOP carry a zero data byte.
    // The 8-bit address bytes are the 7-bit address 0x3E shifted left by one:
    // 0x7C for a write and 0x7D for a read.
    function automatic logic [9:0] prog_entry(input logic [3:0] idx);
        logic [9:0] e;
        case (idx)
            4'd0:    e = {OP_START, 8'h00};
            4'd1:    e = {OP_WRITE, 8'h7C};
            4'd2:    e = {OP_WRITE, 8'h02};
            4'd3:    e = {OP_WRITE, 8'h01};
            4'd4:    e = {OP_STOP,  8'h00};
`ifdef FMC_I2C_READBACK_EN
            4'd5:    e = {OP_START, 8'h00};
            4'd6:    e = {OP_WRITE, 8'h7C};
            4'd7:    e = {OP_WRITE, 8'h02};
            4'd8:    e = {OP_START, 8'h00};
            4'd9:    e = {OP_WRITE, 8'h7D};
            4'd10:   e = {OP_READ,  8'h01};
            4'd11:   e = {OP_STOP,  8'h00};
`endif
            default: e = {OP_STOP,  8'h00};
        endcase
        return e;
    endfunction

    // Index of the program step that follows the current one
    always_comb begin
        step_d = step_q + 4'd1;
    end

    // Sequencer FSM; every output is registered here
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= 4'd0;
            retry_cnt_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 2'b00;
            cmd_data_q  <= 8'h00;
            rd_byte_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (go) begin
                        state_q                <= S_ISSUE;
                        step_q                 <= 4'd0;
                        retry_cnt_q            <= '0;
                        error_q                <= 1'b0;
                        err_code_q             <= ERR_NONE;
                        busy_q                 <= 1'b1;
                        cmd_valid_q            <= 1'b1;
                        {cmd_op_q, cmd_data_q} <= prog_entry(4'd0);
                    end
                end

                S_ISSUE: begin
                    if (cmd_valid_q && cmd_ready) begin
                        state_q     <= S_WAIT_RSP;
                        cmd_valid_q <= 1'b0;
                        timer_q     <= '0;
                    end
                end

                S_WAIT_RSP: begin
                    // If a response arrives in the expiry cycle, the response is processed
                    // and no timeout is flagged.
                    if (rsp_valid) begin
                        if (cmd_op_q == OP_READ) begin
                            rd_byte_q <= rsp_data;
                        end
                        if (cmd_op_q == OP_WRITE && rsp_nack) begin
                            state_q     <= S_RECOVER;
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= OP_STOP;
                            cmd_data_q  <= 8'h00;
                        end else if (step_q == LAST_STEP) begin
`ifdef FMC_I2C_READBACK_EN
                            if (rd_byte_q != 8'h01) begin
                                state_q    <= S_FAIL;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                                err_code_q <= ERR_MISMATCH;
                            end else begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
`else
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            step_q                 <= step_d;
                            state_q                <= S_ISSUE;
                            cmd_valid_q            <= 1'b1;
                            {cmd_op_q, cmd_data_q} <= prog_entry(step_d);
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= S_FAIL;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                S_RECOVER: begin
                    if (cmd_valid_q && cmd_ready) begin
                        state_q     <= S_REC_WAIT;
                        cmd_valid_q <= 1'b0;
                        timer_q     <= '0;
                    end
                end

                S_REC_WAIT: begin
                    if (rsp_valid) begin
                        if (retry_cnt_q < RW'(RETRY_MAX)) begin
                            retry_cnt_q            <= retry_cnt_q + RW'(1);
                            step_q                 <= 4'd0;
                            state_q                <= S_ISSUE;
                            cmd_valid_q            <= 1'b1;
                            {cmd_op_q, cmd_data_q} <= prog_entry(4'd0);
                        end else begin
                            state_q    <= S_FAIL;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_NACK;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= S_FAIL;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_data  = cmd_data_q;
    assign rd_byte   = rd_byte_q;

endmodule

// File: tb/tb_fmc_i2c_cmd_sequencer.sv
// Directed bench for fmc_i2c_cmd_sequencer. It plays the I2C controller: it accepts
// commands, logs them, and answers each one a few cycles later.
module tb_fmc_i2c_cmd_sequencer;

    localparam int TMO    = 50;
    localparam int RMAX   = 3;
    localparam int BUDGET = 3000;

`ifdef FMC_I2C_READBACK_EN
    localparam int PLEN = 12;
`else
    localparam int PLEN = 5;
`endif

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid = 1'b0;
    logic       rsp_nack = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic [7:0] rd_byte;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [1:0] op_log  [64];
    logic [7:0] dat_log [64];
    logic [1:0] exp_op  [PLEN];
    logic [7:0] exp_dat [PLEN];
    int  n_cmd, done_cnt, unstable, acc_cyc, end_cyc;
    bit  ended;

    fmc_i2c_cmd_sequencer #(.RETRY_MAX(RMAX), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .reset(reset), .go(go), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_nack(rsp_nack), .rsp_data(rsp_data), .rd_byte(rd_byte)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction as seen by the controller.
    // nack_mode: 0 = always ACK, 1 = NACK only the first WRITE 0x7C, 2 = NACK every WRITE.
    // withhold: command index whose response is never sent (-1 = none).
    task automatic run_txn(input int nack_mode, input int rdy_dly, input bit go_spam,
                           input int withhold, input bit abort, input logic [7:0] rdata);
        int cyc;
        int idx;
        bit nacked;
        logic [1:0] op;
        logic [7:0] d;
        cyc = 0; nacked = 0; n_cmd = 0; done_cnt = 0; unstable = 0;
        ended = 0; acc_cyc = -1; end_cyc = -1;
        go = 1'b1;
        @(negedge CLK); cyc++;
        go = 1'b0;
        chk("go_busy", {31'd0, busy}, 32'd1);
        chk("go_err_clear", {29'd0, error, err_code}, 32'd0);
        while (cyc < BUDGET) begin
            @(negedge CLK); cyc++;
            if (done) done_cnt++;
            if (!busy) begin ended = 1; end_cyc = cyc; break; end
            if (cmd_valid) begin
                op = cmd_op; d = cmd_data;
                for (int k = 0; k < rdy_dly; k++) begin
                    if (go_spam && k == 3) go = 1'b1;
                    if (go_spam && k == 4) go = 1'b0;
                    @(negedge CLK); cyc++;
                    if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_data !== d) unstable++;
                end
                go = 1'b0;
                cmd_ready = 1'b1;
                @(negedge CLK); cyc++;
                cmd_ready = 1'b0;
                if (cmd_valid !== 1'b0) unstable++;
                idx = n_cmd;
                if (n_cmd < 64) begin
                    op_log[idx] = op; dat_log[idx] = d; n_cmd++;
                end
                if (idx == withhold) begin
                    acc_cyc = cyc;
                    if (abort) return;
                end else begin
                    repeat (2) begin @(negedge CLK); cyc++; end
                    rsp_nack = (op == 2'b01) &&
                               (nack_mode == 2 || (nack_mode == 1 && d == 8'h7C && !nacked));
                    if (rsp_nack) nacked = 1;
                    rsp_data = rdata;
                    rsp_valid = 1'b1;
                    @(negedge CLK); cyc++;
                    rsp_valid = 1'b0; rsp_nack = 1'b0;
                    if (done) done_cnt++;
                    if (!busy) begin ended = 1; end_cyc = cyc; break; end
                end
            end
        end
    endtask

    initial begin
`ifdef FMC_I2C_READBACK_EN
        exp_op  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
        exp_dat = '{8'h00, 8'h7C, 8'h02, 8'h01, 8'h00, 8'h00, 8'h7C, 8'h02, 8'h00, 8'h7D, 8'h01, 8'h00};
`else
        exp_op  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        exp_dat = '{8'h00, 8'h7C, 8'h02, 8'h01, 8'h00};
`endif
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {29'd0, error, err_code}, 32'd0);
        chk("rst_cmd", {21'd0, cmd_valid, cmd_op, cmd_data}, 32'd0);
        chk("rst_rd_byte", {24'd0, rd_byte}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge CLK);

        // 1: clean transaction
        run_txn(0, 0, 0, -1, 0, 8'h01);
        chk("t1_ended", {31'd0, ended}, 32'd1);
        chk("t1_ncmd", n_cmd, PLEN);
        for (int i = 0; i < PLEN; i++) begin
            chk($sformatf("t1_op%0d", i), {30'd0, op_log[i]}, {30'd0, exp_op[i]});
            if (exp_op[i] == 2'b01 || exp_op[i] == 2'b10)
                chk($sformatf("t1_dat%0d", i), {24'd0, dat_log[i]}, {24'd0, exp_dat[i]});
        end
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_error", {29'd0, error, err_code}, 32'd0);
`ifdef FMC_I2C_READBACK_EN
        chk("t1_rd_byte", {24'd0, rd_byte}, 32'h01);
`else
        chk("t1_rd_byte", {24'd0, rd_byte}, 32'h00);
`endif
        @(negedge CLK);
        chk("t1_done_1cyc", {31'd0, done}, 32'd0);

        // 2: single NACK on the first WRITE 0x7C, then a successful retry
        run_txn(1, 0, 0, -1, 0, 8'h01);
        chk("t2_ncmd", n_cmd, PLEN + 3);
        chk("t2_stop", {30'd0, op_log[2]}, 32'd3);
        chk("t2_restart", {30'd0, op_log[3]}, 32'd0);
        chk("t2_rewrite", {24'd0, dat_log[4]}, 32'h7C);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_error", {29'd0, error, err_code}, 32'd0);

        // 3: NACK on every WRITE, so all retries are exhausted
        run_txn(2, 0, 0, -1, 0, 8'h01);
        chk("t3_ncmd", n_cmd, 3 * (RMAX + 1));
        for (int a = 0; a <= RMAX; a++)
            chk($sformatf("t3_stop%0d", a), {30'd0, op_log[3 * a + 2]}, 32'd3);
        chk("t3_done_cnt", done_cnt, 0);
        chk("t3_error", {29'd0, error, err_code}, 32'b101);

        // 4: response to WRITE 0x02 withheld, which must time out
        run_txn(0, 0, 0, 2, 0, 8'h01);
        chk("t4_ended", {31'd0, ended}, 32'd1);
        chk("t4_wdat", {24'd0, dat_log[2]}, 32'h02);
        chk("t4_latency", end_cyc - acc_cyc, TMO);
        chk("t4_no_stop", n_cmd, 3);
        chk("t4_error", {29'd0, error, err_code}, 32'b110);
        chk("t4_done_cnt", done_cnt, 0);

        // 5: slow cmd_ready plus go pulses while busy
        run_txn(0, 10, 1, -1, 0, 8'h01);
        chk("t5_stable", unstable, 0);
        chk("t5_ncmd", n_cmd, PLEN);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_error", {29'd0, error, err_code}, 32'd0);

`ifdef FMC_I2C_READBACK_EN
        // 6: readback returns 0x00, which is a mismatch
        run_txn(0, 0, 0, -1, 0, 8'h00);
        chk("t6_ncmd", n_cmd, PLEN);
        chk("t6_rd_byte", {24'd0, rd_byte}, 32'h00);
        chk("t6_error", {29'd0, error, err_code}, 32'b111);
        chk("t6_done_cnt", done_cnt, 0);
`endif

        // Reset asserted while waiting for the WRITE 0x7C response
        run_txn(0, 0, 0, 1, 1, 8'h01);
        repeat (3) @(negedge CLK);
        chk("rm_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rm_busy", {31'd0, busy}, 32'd0);
        chk("rm_cmd", {21'd0, cmd_valid, cmd_op, cmd_data}, 32'd0);
        chk("rm_status", {28'd0, done, error, err_code}, 32'd0);
        chk("rm_rd_byte", {24'd0, rd_byte}, 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rm_idle", {30'd0, busy, cmd_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
